// File: rtl/PARAMS_pkg.sv
// Shared core parameters: datapath width, register index width and derived regfile types.
// Pure declarations; no logic.
package PARAMS_pkg;
   localparam int WD_SIZE        = 32;
   localparam int INSTR_REG_BITS = 5;
   localparam int NUM_REGS       = 2 ** INSTR_REG_BITS;

   typedef logic [INSTR_REG_BITS-1:0] reg_idx_t;
   typedef logic [WD_SIZE-1:0]        word_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue of a writing instruction, cleared on write-back.
// Busy vector updates on the clock edge; set beats clear on the same index; x0 never busy.
module reg_scoreboard
   import PARAMS_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                set_i,
   input  reg_idx_t            set_idx_i,
   input  logic                clr_i,
   input  reg_idx_t            clr_idx_i,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_i) begin
         busy_d[clr_idx_i] = 1'b0;
      end
      // Applied after the clear so a simultaneous set on the same register wins.
      if (set_i) begin
         busy_d[set_idx_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/register_file.sv
// Integer register file with write-back bypass and a busy scoreboard driving a decode stall.
// Reads and stall are combinational (0 cycles); writes land on the edge; stall blocks scoreboard set.
module register_file
   import PARAMS_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en_i,
   input  logic [INSTR_REG_BITS-1:0] rd_i,
   input  logic [WD_SIZE-1:0] wr_data_i,
   input  logic [INSTR_REG_BITS-1:0] rs1_i,
   input  logic [INSTR_REG_BITS-1:0] rs2_i,
   output logic [WD_SIZE-1:0] rs1_data_o,
   output logic [WD_SIZE-1:0] rs2_data_o,
   input  logic               issue_i,
   input  logic [INSTR_REG_BITS-1:0] issue_rd_i,
   input  logic               issue_wr_i,
   output logic               stall_o
);

   word_t               regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                byp_rs1;
   logic                byp_rs2;
   logic                haz_rs1;
   logic                haz_rs2;
   logic                sb_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_i && (rd_i != '0)) begin
         regs_q[rd_i] <= wr_data_i;
      end
   end

   always_comb begin
      byp_rs1 = BYPASS_EN && wr_en_i && (rd_i == rs1_i) && (rs1_i != '0);
      byp_rs2 = BYPASS_EN && wr_en_i && (rd_i == rs2_i) && (rs2_i != '0);

      rs1_data_o = byp_rs1 ? wr_data_i : regs_q[rs1_i];
      rs2_data_o = byp_rs2 ? wr_data_i : regs_q[rs2_i];

      // A bypassed operand is already available, so its pending write no longer blocks decode.
      haz_rs1 = (rs1_i != '0) && busy[rs1_i] && !byp_rs1;
      haz_rs2 = (rs2_i != '0) && busy[rs2_i] && !byp_rs2;
      stall_o = haz_rs1 || haz_rs2;

      sb_set  = issue_i && issue_wr_i && !stall_o;
   end

   reg_scoreboard u_scoreboard (
      .clk       (clk),
      .reset_n   (reset_n),
      .set_i     (sb_set),
      .set_idx_i (issue_rd_i),
      .clr_i     (wr_en_i),
      .clr_idx_i (rd_i),
      .busy_o    (busy)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed bench: two instances (bypass on / off) share all inputs and are checked side by side.
module tb_register_file;
   import PARAMS_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        wr_en;
   reg_idx_t    rd;
   word_t       wr_data;
   reg_idx_t    rs1;
   reg_idx_t    rs2;
   logic        issue;
   reg_idx_t    issue_rd;
   logic        issue_wr;

   word_t       b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
   logic        b_stall, n_stall;

   int          tests  = 0;
   int          failed = 0;

   register_file #(.BYPASS_EN(1'b1)) u_byp (
      .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en), .rd_i(rd), .wr_data_i(wr_data),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_data_o(b_rs1_data), .rs2_data_o(b_rs2_data),
      .issue_i(issue), .issue_rd_i(issue_rd), .issue_wr_i(issue_wr), .stall_o(b_stall)
   );

   register_file #(.BYPASS_EN(1'b0)) u_nob (
      .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en), .rd_i(rd), .wr_data_i(wr_data),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_data_o(n_rs1_data), .rs2_data_o(n_rs2_data),
      .issue_i(issue), .issue_rd_i(issue_rd), .issue_wr_i(issue_wr), .stall_o(n_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      wr_en = 1'b0; rd = '0; wr_data = '0;
      issue = 1'b0; issue_rd = '0; issue_wr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      quiet();
      rs1 = 5'd7; rs2 = 5'd9;
      #3;
      chk("rst_stall_byp", 32'(b_stall), 32'd0);
      chk("rst_stall_nob", 32'(n_stall), 32'd0);
      chk("rst_rs1_byp", b_rs1_data, 32'h0);
      // Bypass path stays live in reset; the stored value does not.
      wr_en = 1'b1; rd = 5'd7; wr_data = 32'hCAFE0001;
      #1;
      chk("rst_bypass_rs1", b_rs1_data, 32'hCAFE0001);
      chk("rst_nobypass_rs1", n_rs1_data, 32'h0);
      quiet();
      #18 reset_n = 1'b1;
      tick();

      // Every index reads zero, no stall.
      for (int i = 0; i < NUM_REGS; i++) begin
         rs1 = reg_idx_t'(i);
         rs2 = reg_idx_t'(NUM_REGS - 1 - i);
         #1;
         chk("idle_rs1", b_rs1_data, 32'h0);
         chk("idle_rs2", n_rs2_data, 32'h0);
         chk("idle_stall", 32'({b_stall, n_stall}), 32'd0);
      end

      // Basic write then read next cycle.
      rs1 = '0; rs2 = '0;
      wr_en = 1'b1; rd = 5'd5; wr_data = 32'hDEADBEEF;
      tick();
      quiet();
      rs1 = 5'd5;
      #1;
      chk("x5_byp", b_rs1_data, 32'hDEADBEEF);
      chk("x5_nob", n_rs1_data, 32'hDEADBEEF);

      // x0 is hard-wired, including against bypass.
      wr_en = 1'b1; rd = 5'd0; wr_data = 32'h1234; rs2 = 5'd0;
      #1;
      chk("x0_same_cycle_byp", b_rs2_data, 32'h0);
      tick();
      quiet();
      #1;
      chk("x0_after_byp", b_rs2_data, 32'h0);
      chk("x0_after_nob", n_rs2_data, 32'h0);

      // Same-cycle write to idle x7.
      wr_en = 1'b1; rd = 5'd7; wr_data = 32'h55; rs1 = 5'd7;
      #1;
      chk("x7_byp_data", b_rs1_data, 32'h55);
      chk("x7_byp_stall", 32'(b_stall), 32'd0);
      chk("x7_nob_old", n_rs1_data, 32'h0);
      chk("x7_nob_stall", 32'(n_stall), 32'd0);
      tick();
      quiet();
      #1;
      chk("x7_nob_stored", n_rs1_data, 32'h55);

      // Busy x7, then write-back in the same cycle as the read.
      rs1 = '0;
      issue = 1'b1; issue_rd = 5'd7; issue_wr = 1'b1;
      tick();
      quiet();
      rs1 = 5'd7;
      #1;
      chk("x7_busy_stall_byp", 32'(b_stall), 32'd1);
      chk("x7_busy_stall_nob", 32'(n_stall), 32'd1);
      wr_en = 1'b1; rd = 5'd7; wr_data = 32'h77;
      #1;
      chk("x7_wb_byp_data", b_rs1_data, 32'h77);
      chk("x7_wb_byp_stall", 32'(b_stall), 32'd0);
      chk("x7_wb_nob_data", n_rs1_data, 32'h55);
      chk("x7_wb_nob_stall", 32'(n_stall), 32'd1);
      tick();
      quiet();
      #1;
      chk("x7_post_nob_stall", 32'(n_stall), 32'd0);
      chk("x7_post_nob_data", n_rs1_data, 32'h77);

      // Issue rd=3; stalled issue of rd=9 must be ignored.
      rs1 = '0;
      issue = 1'b1; issue_rd = 5'd3; issue_wr = 1'b1;
      tick();
      rs2 = 5'd3; issue_rd = 5'd9;
      #1;
      chk("x3_stall_byp", 32'(b_stall), 32'd1);
      chk("x3_stall_nob", 32'(n_stall), 32'd1);
      tick();
      issue = 1'b0; issue_wr = 1'b0;
      wr_en = 1'b1; rd = 5'd3; wr_data = 32'hA5;
      #1;
      chk("x3_wb_stall_byp", 32'(b_stall), 32'd0);
      chk("x3_wb_data_byp", b_rs2_data, 32'hA5);
      tick();
      quiet();
      #1;
      chk("x3_idle_byp", 32'(b_stall), 32'd0);
      chk("x3_idle_nob", 32'(n_stall), 32'd0);
      rs2 = '0; rs1 = 5'd9;
      #1;
      chk("x9_not_set", 32'({b_stall, n_stall}), 32'd0);

      // Non-writing instruction does not mark busy.
      rs1 = '0;
      issue = 1'b1; issue_rd = 5'd10; issue_wr = 1'b0;
      tick();
      quiet();
      rs1 = 5'd10;
      #1;
      chk("x10_store_no_busy", 32'({b_stall, n_stall}), 32'd0);

      // Set and clear of x4 on the same edge: set wins, data lands.
      rs1 = '0;
      issue = 1'b1; issue_rd = 5'd4; issue_wr = 1'b1;
      wr_en = 1'b1; rd = 5'd4; wr_data = 32'h44;
      tick();
      quiet();
      rs1 = 5'd4;
      #1;
      chk("x4_busy_byp", 32'(b_stall), 32'd1);
      chk("x4_busy_nob", 32'(n_stall), 32'd1);
      chk("x4_data", b_rs1_data, 32'h44);
      wr_en = 1'b1; rd = 5'd4; wr_data = 32'h45;
      tick();
      quiet();
      #1;
      chk("x4_cleared", 32'({b_stall, n_stall}), 32'd0);

      // Reset mid-flight with x6 busy and a write pending.
      rs1 = '0;
      wr_en = 1'b1; rd = 5'd6; wr_data = 32'h66;
      tick();
      quiet();
      issue = 1'b1; issue_rd = 5'd6; issue_wr = 1'b1;
      tick();
      quiet();
      rs1 = 5'd6;
      #1;
      chk("x6_busy_pre_rst", 32'(b_stall), 32'd1);
      wr_en = 1'b1; rd = 5'd6; wr_data = 32'h99;
      #1 reset_n = 1'b0;
      #1;
      chk("x6_rst_stall", 32'({b_stall, n_stall}), 32'd0);
      chk("x6_rst_nob_data", n_rs1_data, 32'h0);
      quiet();
      tick();
      #2 reset_n = 1'b1;
      #1;
      chk("x6_rel_stall", 32'({b_stall, n_stall}), 32'd0);
      chk("x6_rel_byp_data", b_rs1_data, 32'h0);
      chk("x6_rel_nob_data", n_rs1_data, 32'h0);
      tick();
      wr_en = 1'b1; rd = 5'd6; wr_data = 32'h1;
      tick();
      quiet();
      #1;
      chk("x6_write_after_rel", n_rs1_data, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
